// File: rtl/scarv_cop_cprs.sv
// rtl/scarv_cop_cprs.sv - coprocessor register file with dual writeback, byte enables and busy scoreboard
//
// Ports:
//   g_clk, g_resetn           clock, asynchronous active-low reset
//   cprs_rs{1,2,3}_addr       read port indices
//   cprs_rs{1,2,3}_rdata      combinational read data
//   palu_cpr_rd_{addr,ben,wdata}  PALU writeback (byte enables)
//   mem_cpr_rd_{addr,ben,wdata}   memory-unit writeback (byte enables)
//   issue_valid, issue_rd_addr    multi-cycle destination reservation
//   cprs_busy                 per-register write-pending scoreboard
module scarv_cop_cprs #(
    parameter bit BYPASS = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_resetn,

    input  logic [3:0]  cprs_rs1_addr,
    output logic [31:0] cprs_rs1_rdata,
    input  logic [3:0]  cprs_rs2_addr,
    output logic [31:0] cprs_rs2_rdata,
    input  logic [3:0]  cprs_rs3_addr,
    output logic [31:0] cprs_rs3_rdata,

    input  logic [3:0]  palu_cpr_rd_addr,
    input  logic [3:0]  palu_cpr_rd_ben,
    input  logic [31:0] palu_cpr_rd_wdata,

    input  logic [3:0]  mem_cpr_rd_addr,
    input  logic [3:0]  mem_cpr_rd_ben,
    input  logic [31:0] mem_cpr_rd_wdata,

    input  logic        issue_valid,
    input  logic [3:0]  issue_rd_addr,

    output logic [15:0] cprs_busy
);

    logic [31:0] regs     [16];
    logic [31:0] regs_nxt [16];
    logic [15:0] set_vec;
    logic [15:0] clr_vec;
    logic [15:0] busy_nxt;

    // Per-byte merge of both writeback ports. PALU has priority on any
    // byte it enables; memory fills bytes PALU leaves alone.
    always_comb begin
        for (int n = 0; n < 16; n++) begin
            regs_nxt[n] = regs[n];
            for (int b = 0; b < 4; b++) begin
                if (palu_cpr_rd_addr == n[3:0] && palu_cpr_rd_ben[b]) begin
                    regs_nxt[n][8*b +: 8] = palu_cpr_rd_wdata[8*b +: 8];
                end else if (mem_cpr_rd_addr == n[3:0] && mem_cpr_rd_ben[b]) begin
                    regs_nxt[n][8*b +: 8] = mem_cpr_rd_wdata[8*b +: 8];
                end
            end
        end
    end

    // A write only retires a pending result if it actually touches a byte.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid) begin
            set_vec[issue_rd_addr] = 1'b1;
        end
        if (|palu_cpr_rd_ben) begin
            clr_vec[palu_cpr_rd_addr] = 1'b1;
        end
        if (|mem_cpr_rd_ben) begin
            clr_vec[mem_cpr_rd_addr] = 1'b1;
        end
        // Set applied after clear so a same-cycle issue keeps the bit busy.
        busy_nxt = (cprs_busy & ~clr_vec) | set_vec;
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            for (int n = 0; n < 16; n++) begin
                regs[n] <= '0;
            end
            cprs_busy <= '0;
        end else begin
            for (int n = 0; n < 16; n++) begin
                regs[n] <= regs_nxt[n];
            end
            cprs_busy <= busy_nxt;
        end
    end

    // Forwarding path would otherwise leak writeback data while in reset,
    // so the outputs are forced to zero for the duration of reset.
    always_comb begin
        cprs_rs1_rdata = '0;
        cprs_rs2_rdata = '0;
        cprs_rs3_rdata = '0;
        if (g_resetn) begin
            if (BYPASS) begin
                cprs_rs1_rdata = regs_nxt[cprs_rs1_addr];
                cprs_rs2_rdata = regs_nxt[cprs_rs2_addr];
                cprs_rs3_rdata = regs_nxt[cprs_rs3_addr];
            end else begin
                cprs_rs1_rdata = regs[cprs_rs1_addr];
                cprs_rs2_rdata = regs[cprs_rs2_addr];
                cprs_rs3_rdata = regs[cprs_rs3_addr];
            end
        end
    end

endmodule

// File: tb/tb_scarv_cop_cprs.sv
// tb/tb_scarv_cop_cprs.sv - scoreboard bench for scarv_cop_cprs (bypass and non-bypass instances)
module tb_scarv_cop_cprs;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  rs1_addr = '0, rs2_addr = '0, rs3_addr = '0;
    logic [31:0] rs1_rdata, rs2_rdata, rs3_rdata;
    logic [31:0] nb_rs1_rdata, nb_rs2_rdata, nb_rs3_rdata;
    logic [3:0]  palu_addr = '0, palu_ben = '0;
    logic [31:0] palu_wdata = '0;
    logic [3:0]  mem_addr = '0, mem_ben = '0;
    logic [31:0] mem_wdata = '0;
    logic        issue_valid = 1'b0;
    logic [3:0]  issue_addr = '0;
    logic [15:0] busy, nb_busy;

    always #5 clk = ~clk;

    scarv_cop_cprs #(.BYPASS(1'b1)) u_dut (
        .g_clk(clk), .g_resetn(resetn),
        .cprs_rs1_addr(rs1_addr), .cprs_rs1_rdata(rs1_rdata),
        .cprs_rs2_addr(rs2_addr), .cprs_rs2_rdata(rs2_rdata),
        .cprs_rs3_addr(rs3_addr), .cprs_rs3_rdata(rs3_rdata),
        .palu_cpr_rd_addr(palu_addr), .palu_cpr_rd_ben(palu_ben), .palu_cpr_rd_wdata(palu_wdata),
        .mem_cpr_rd_addr(mem_addr), .mem_cpr_rd_ben(mem_ben), .mem_cpr_rd_wdata(mem_wdata),
        .issue_valid(issue_valid), .issue_rd_addr(issue_addr),
        .cprs_busy(busy)
    );

    scarv_cop_cprs #(.BYPASS(1'b0)) u_nb (
        .g_clk(clk), .g_resetn(resetn),
        .cprs_rs1_addr(rs1_addr), .cprs_rs1_rdata(nb_rs1_rdata),
        .cprs_rs2_addr(rs2_addr), .cprs_rs2_rdata(nb_rs2_rdata),
        .cprs_rs3_addr(rs3_addr), .cprs_rs3_rdata(nb_rs3_rdata),
        .palu_cpr_rd_addr(palu_addr), .palu_cpr_rd_ben(palu_ben), .palu_cpr_rd_wdata(palu_wdata),
        .mem_cpr_rd_addr(mem_addr), .mem_cpr_rd_ben(mem_ben), .mem_cpr_rd_wdata(mem_wdata),
        .issue_valid(issue_valid), .issue_rd_addr(issue_addr),
        .cprs_busy(nb_busy)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] ref_regs [16];
    logic [15:0] ref_busy;

    string       q_tag [$];
    logic [31:0] q_exp [$];
    int          q_sel [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merged(input int a);
        logic [31:0] r;
        r = ref_regs[a];
        for (int b = 0; b < 4; b++) begin
            if (palu_addr == a[3:0] && palu_ben[b])
                r[8*b +: 8] = palu_wdata[8*b +: 8];
            else if (mem_addr == a[3:0] && mem_ben[b])
                r[8*b +: 8] = mem_wdata[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] exp_byp(input logic [3:0] a);
        return resetn ? merged(int'(a)) : 32'h0;
    endfunction

    function automatic logic [31:0] exp_nb(input logic [3:0] a);
        return resetn ? ref_regs[a] : 32'h0;
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        q_tag.push_back(tag);
        q_sel.push_back(sel);
        q_exp.push_back(exp);
    endtask

    task automatic drain();
        logic [31:0] obs;
        while (q_exp.size() > 0) begin
            case (q_sel[0])
                0: obs = rs1_rdata;
                1: obs = rs2_rdata;
                2: obs = rs3_rdata;
                3: obs = {16'h0, busy};
                4: obs = nb_rs1_rdata;
                5: obs = nb_rs2_rdata;
                6: obs = nb_rs3_rdata;
                default: obs = {16'h0, nb_busy};
            endcase
            check(q_tag[0], obs, q_exp[0]);
            void'(q_tag.pop_front());
            void'(q_sel.pop_front());
            void'(q_exp.pop_front());
        end
    endtask

    task automatic update_model();
        logic [31:0] nxt [16];
        logic [15:0] clr, set;
        for (int a = 0; a < 16; a++) nxt[a] = merged(a);
        clr = '0;
        set = '0;
        if (palu_ben != 4'h0) clr[palu_addr] = 1'b1;
        if (mem_ben != 4'h0) clr[mem_addr] = 1'b1;
        if (issue_valid) set[issue_addr] = 1'b1;
        for (int a = 0; a < 16; a++) ref_regs[a] = nxt[a];
        ref_busy = (ref_busy & ~clr) | set;
    endtask

    task automatic reset_model();
        for (int a = 0; a < 16; a++) ref_regs[a] = '0;
        ref_busy = '0;
    endtask

    // Entered at posedge+1: queue expectations, sample at the falling edge,
    // then let the rising edge commit and advance the model.
    task automatic step(input string tag);
        push({tag, ".rs1"}, 0, exp_byp(rs1_addr));
        push({tag, ".rs2"}, 1, exp_byp(rs2_addr));
        push({tag, ".rs3"}, 2, exp_byp(rs3_addr));
        push({tag, ".busy"}, 3, {16'h0, ref_busy});
        push({tag, ".nb_rs1"}, 4, exp_nb(rs1_addr));
        push({tag, ".nb_rs2"}, 5, exp_nb(rs2_addr));
        push({tag, ".nb_rs3"}, 6, exp_nb(rs3_addr));
        push({tag, ".nb_busy"}, 7, {16'h0, ref_busy});
        #4;
        drain();
        @(posedge clk);
        if (resetn) update_model();
        #1;
    endtask

    task automatic idle();
        palu_ben = '0;
        mem_ben = '0;
        issue_valid = 1'b0;
    endtask

    task automatic palu_wr(input logic [3:0] a, input logic [3:0] ben, input logic [31:0] d);
        palu_addr = a; palu_ben = ben; palu_wdata = d;
    endtask

    task automatic mem_wr(input logic [3:0] a, input logic [3:0] ben, input logic [31:0] d);
        mem_addr = a; mem_ben = ben; mem_wdata = d;
    endtask

    initial begin
        reset_model();
        @(posedge clk);
        #1;

        // Writes and issues during reset must be discarded, reads forced to 0.
        palu_wr(4'd2, 4'hF, 32'hCAFEF00D);
        issue_valid = 1'b1; issue_addr = 4'd2;
        rs1_addr = 4'd2;
        step("in_reset");
        step("in_reset2");

        // Release between edges with a write pending: accepted at that edge.
        idle();
        resetn = 1'b1;
        palu_wr(4'd6, 4'hF, 32'hA5A5A5A5);
        rs1_addr = 4'd6;
        step("first_wr");
        idle();
        step("first_wr_vis");
        palu_wr(4'd6, 4'hF, 32'h0);
        step("clear_c6");
        idle();

        for (int i = 0; i < 16; i++) begin
            rs1_addr = 4'(i);
            rs2_addr = 4'(15 - i);
            rs3_addr = 4'((i + 5) % 16);
            step($sformatf("zero_c%0d", i));
        end

        // Byte-enabled PALU overwrite of c5.
        rs1_addr = 4'd5;
        palu_wr(4'd5, 4'hF, 32'hDEADBEEF);
        step("c5_full");
        palu_wr(4'd5, 4'h2, 32'h00001100);
        step("c5_byte1");
        idle();
        step("c5_final");
        check("c5_const", rs1_rdata, 32'hDEAD11EF);

        // Same-address collision, PALU priority per byte.
        rs1_addr = 4'd3;
        palu_wr(4'd3, 4'h3, 32'h0000AAAA);
        mem_wr(4'd3, 4'hE, 32'h55555500);
        #1;
        check("c3_bypass_const", rs1_rdata, 32'h5555AAAA);
        #(-1 + 1);
        step("c3_merge");
        idle();
        step("c3_final");

        // Different addresses in the same cycle, c0 is writable.
        rs1_addr = 4'd0; rs2_addr = 4'd15;
        palu_wr(4'd0, 4'hF, 32'h01020304);
        mem_wr(4'd15, 4'h9, 32'hF00000F0);
        step("dual_wr");
        idle();
        step("dual_wr_vis");

        // Scoreboard: set, set-wins-over-clear, second issue.
        issue_valid = 1'b1; issue_addr = 4'd7;
        step("issue_c7");
        idle();
        check("busy_c7_const", {16'h0, busy}, 32'h0000_0080);
        palu_wr(4'd7, 4'hF, 32'h77777777);
        issue_valid = 1'b1; issue_addr = 4'd7;
        step("set_wins_c7");
        idle();
        issue_valid = 1'b1; issue_addr = 4'd2;
        step("issue_c2");
        idle();
        check("busy_c7_c2_const", {16'h0, busy}, 32'h0000_0084);

        // Issue + memory write same cycle, then ben=0 write, then ben=1 write.
        rs1_addr = 4'd9;
        issue_valid = 1'b1; issue_addr = 4'd9;
        mem_wr(4'd9, 4'hF, 32'h99999999);
        step("issue_wr_c9");
        idle();
        palu_wr(4'd9, 4'h0, 32'hFFFFFFFF);
        step("ben0_c9");
        idle();
        step("ben0_c9_vis");
        check("busy9_const", {31'h0, busy[9]}, 32'h1);
        mem_wr(4'd9, 4'h1, 32'h000000AB);
        step("ben1_c9");
        idle();
        step("ben1_c9_vis");

        // Randomised traffic.
        for (int i = 0; i < 300; i++) begin
            idle();
            rs1_addr = 4'($urandom_range(0, 15));
            rs2_addr = 4'($urandom_range(0, 15));
            rs3_addr = ($urandom_range(0, 3) == 0) ? palu_addr : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) != 0) palu_wr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 2) != 0) mem_wr(($urandom_range(0, 3) == 0) ? palu_addr : 4'($urandom_range(0, 15)),
                                                  4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 2) == 0) begin
                issue_valid = 1'b1;
                issue_addr = 4'($urandom_range(0, 15));
            end
            step("rand");
        end

        // Asynchronous reset mid-cycle.
        idle();
        rs1_addr = 4'd1; rs2_addr = 4'd4;
        palu_wr(4'd1, 4'hF, 32'h12345678);
        step("c1_wr");
        idle();
        issue_valid = 1'b1; issue_addr = 4'd4;
        step("issue_c4");
        idle();
        check("c1_before_rst", rs1_rdata, 32'h12345678);
        check("busy4_before_rst", {31'h0, busy[4]}, 32'h1);
        palu_wr(4'd1, 4'hF, 32'hFFFFFFFF);
        #1;
        resetn = 1'b0;
        #1;
        check("rst_async_c1", rs1_rdata, 32'h0);
        check("rst_async_busy", {16'h0, busy}, 32'h0);
        check("rst_async_nb_c1", nb_rs1_rdata, 32'h0);
        reset_model();
        #2;
        @(posedge clk);
        #1;
        idle();
        step("held_rst");
        resetn = 1'b1;
        step("post_rst_c1");
        check("post_rst_busy", {16'h0, busy}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
